// File: rtl/cp0_regs.sv
// cp0_regs: MIPS-style coprocessor-0 register file (SR, Cause, EPC, PrID).
// Optional feature macro: CP0_COUNT_EN adds the Count/Compare timer (indices 9
// and 11) whose pending flag is ORed into the IP bit 15 position.
// Reset is asynchronous and active-high; dout and intreq are combinational
// views of registered state, and epc is the EPC register itself.
module cp0_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  a,
   input  logic [31:0] din,
   input  logic [29:0] pc,
   input  logic [5:0]  hwint,
   input  logic        we,
   input  logic        exlset,
   input  logic        exlclr,
   output logic [31:0] dout,
   output logic [29:0] epc,
   output logic        intreq
);

   localparam int unsigned IDX_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned PC_W   = 30;
   localparam int unsigned INT_W  = 6;

   localparam logic [IDX_W-1:0]  IDX_COUNT   = IDX_W'(9);
   localparam logic [IDX_W-1:0]  IDX_COMPARE = IDX_W'(11);
   localparam logic [IDX_W-1:0]  IDX_SR      = IDX_W'(12);
   localparam logic [IDX_W-1:0]  IDX_CAUSE   = IDX_W'(13);
   localparam logic [IDX_W-1:0]  IDX_EPC     = IDX_W'(14);
   localparam logic [IDX_W-1:0]  IDX_PRID    = IDX_W'(15);
   localparam logic [DATA_W-1:0] PRID_VALUE  = 32'h0000_0B01;

   // SR fields
   logic [INT_W-1:0] im;
   logic             exl;
   logic             ie;

   // Cause.IP as sampled from hwint, and the view including the timer flag
   logic [INT_W-1:0] ip;
   logic [INT_W-1:0] ip_eff;

   // Write decode
   logic wr_en;
   logic sr_wr;
   logic epc_wr;

`ifdef CP0_COUNT_EN
   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] compare;
   logic              ti;
   logic              count_wr;
   logic              compare_wr;
`endif

   // Register-write decode; exception entry suppresses any concurrent mtc0
   always_comb begin
      wr_en  = we & ~exlset;
      sr_wr  = wr_en & (a == IDX_SR);
      epc_wr = wr_en & (a == IDX_EPC);
`ifdef CP0_COUNT_EN
      count_wr   = wr_en & (a == IDX_COUNT);
      compare_wr = wr_en & (a == IDX_COMPARE);
`endif
   end

   // SR: exception entry sets EXL; eret clears EXL after any same-cycle mtc0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im  <= '0;
         exl <= 1'b0;
         ie  <= 1'b0;
      end else if (exlset) begin
         exl <= 1'b1;
      end else begin
         if (sr_wr) begin
            im  <= din[15:10];
            exl <= din[1];
            ie  <= din[0];
         end
         if (exlclr) begin
            exl <= 1'b0;
         end
      end
   end

   // IP: one register stage on the asynchronous interrupt lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ip <= '0;
      end else begin
         ip <= hwint;
      end
   end

   // EPC: captured on exception entry, otherwise mtc0-writable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc <= '0;
      end else if (exlset) begin
         epc <= pc;
      end else if (epc_wr) begin
         epc <= din[DATA_W-1:2];
      end
   end

`ifdef CP0_COUNT_EN
   // Count: free-running wrap-around counter, mtc0 load replaces the increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count_wr) begin
         count <= din;
      end else begin
         count <= count + DATA_W'(1);
      end
   end

   // Compare: plain read/write register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare <= '0;
      end else if (compare_wr) begin
         compare <= din;
      end
   end

   // TI: sticky timer match flag, acknowledged by rewriting Compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ti <= 1'b0;
      end else if (compare_wr) begin
         ti <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
         ti <= 1'b1;
      end
   end
`endif

   // Pending-interrupt view: timer flag shares the hwint[5] position
   always_comb begin
      ip_eff = ip;
`ifdef CP0_COUNT_EN
      ip_eff[INT_W-1] = ip[INT_W-1] | ti;
`endif
   end

   // Interrupt request from registered state only
   always_comb begin
      intreq = (|(ip_eff & im)) & ie & ~exl;
   end

   // mfc0 read mux, no read side effects
   always_comb begin
      dout = '0;
      case (a)
         IDX_SR:    dout = {16'h0000, im, 8'h00, exl, ie};
         IDX_CAUSE: dout = {16'h0000, ip_eff, 10'h000};
         IDX_EPC:   dout = {epc, 2'b00};
         IDX_PRID:  dout = PRID_VALUE;
`ifdef CP0_COUNT_EN
         IDX_COUNT:   dout = count;
         IDX_COMPARE: dout = compare;
`endif
         default:   dout = '0;
      endcase
   end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 a  input  5  CP0 register index (instruction rd field, bits 15:11).
REQ-004 din  input  32  mtc0 write data (GPR rt value).
REQ-005 pc  input  30  word address (bits 31:2) to save into EPC on exception entry.
REQ-006 hwint  input  6  external interrupt lines, level, active-high, asynchronous to instruction flow.
REQ-007 we  input  1  register write enable (controller cp0_en).
REQ-008 exlset  input  1  exception entry strobe; sets EXL and captures EPC.
REQ-009 exlclr  input  1  eret strobe; clears EXL.
REQ-010 dout  output  32  read data for register a (mfc0 path), combinational.
REQ-011 epc  output  30  current EPC contents (eret target), registered.
REQ-012 intreq  output  1  interrupt request to the controller, combinational from registered state.

Function
REQ-013 SR (index 12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0 and ignore writes.
REQ-014 Cause (index 13): IP = bits 15:10, read-only; all other bits read 0; writes to index 13 are ignored.
REQ-015 EPC (index 14): bits 31:2 writable; bits 1:0 always read 0.
REQ-016 PrID (index 15): read-only constant 32'h0000_0B01.
REQ-017 Any other index reads 32'h0 and ignores writes, except 9 and 11 when CP0_COUNT_EN is defined.
REQ-018 IP samples hwint every clock: IP <= hwint (plus the timer term in REQ-029); single register stage, no further filtering.
REQ-019 intreq = |(IP & IM) & IE & ~EXL; so intreq lags a hwint edge by exactly one clock.
REQ-020 we=1, exlset=0: register a <= din at the clock edge; the new value is visible on dout and intreq the following cycle.
REQ-021 exlset=1: EXL <= 1 and EPC <= pc in the same edge; any concurrent we write is suppressed, since the controller drives we during interrupt entry with a meaningless a.
REQ-022 exlclr=1, exlset=0: EXL <= 0; IE and IM are unchanged.
REQ-023 exlset and exlclr both 1: exlset wins.
REQ-024 exlclr with we to SR in the same cycle: the EXL bit comes from exlclr (0); the IE and IM bits come from din.
REQ-025 exlset at EXL=1 (nested entry): EPC is still overwritten; no protection is required.
REQ-026 epc output = EPC register; dout is a pure mux of a, with no read side effects.

Reset
REQ-027 rst=1: SR, IP, EPC <= 0 (and Count, Compare, TI <= 0 when configured); intreq=0, epc=0 immediately, with no clock needed.
REQ-028 Reset asserted mid-operation (for example during an exlset cycle) overrides every update; the first capture occurs on the first edge after rst falls.

Configuration
REQ-029 Macro CP0_COUNT_EN defined:
- Count (index 9) increments by 1 every clock and wraps 32'hFFFF_FFFF -> 0.
- Compare (index 11) is read/write.
- A mtc0 to Count loads din in place of the increment.
- Timer pending flag TI sets on the edge where Count == Compare, Compare != 0; a write to Compare clears TI.
- TI is ORed into IP bit 15 (the hwint[5] position).
- Macro absent: indices 9 and 11 read 0, there is no counter logic, and IP bit 15 = hwint[5] only.

Verification
REQ-030 rst pulse, then write SR=32'h0000_FC01 -> next cycle dout (a=12) = 32'h0000_FC01, intreq=0 with hwint=0.
REQ-031 SR=32'h0000_0401, hwint=6'b000001 -> intreq=1 exactly one clock later; Cause read = 32'h0000_0400.
REQ-032 intreq=1, exlset=1, we=1, a=12, din=0, pc=30'h0000_0C05 -> epc=30'h0000_0C05, SR=32'h0000_0403, intreq=0.
REQ-033 After REQ-032, exlclr=1 -> SR=32'h0000_0401; intreq returns to 1 if hwint[0] is still high.
REQ-034 Write a=13 din=32'hFFFF_FFFF, and a=15 -> Cause unchanged; PrID reads 32'h0000_0B01; a=3 reads 0.
REQ-035 (CP0_COUNT_EN) Write Count=0, Compare=5, SR=32'h0000_8001 -> TI and intreq rise after Count reaches 5; writing Compare=5 again clears intreq.
